// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - tile sequencer feeding the PE array from weight/activation SRAMs
// One output channel per tile: CLEAR, K FEED cycles, DRAIN, WAIT, WRITE.
module pe_array_ctrl #(
  parameter int MAC_NUM = 10,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int ADDR_W  = 12,
  parameter int K_W     = 8,
  parameter int T_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [K_W-1:0]              cfg_k_len,
  input  logic [T_W-1:0]              cfg_n_tiles,
  input  logic [ADDR_W-1:0]           cfg_wet_base,
  input  logic [7:0]                  cfg_shift,
  output logic                        busy,
  output logic                        done,
  output logic                        wet_rd_en,
  output logic [ADDR_W-1:0]           wet_rd_addr,
  input  logic [BW_WET-1:0]           wet_rd_data,
  output logic                        act_rd_en,
  output logic [ADDR_W-1:0]           act_rd_addr,
  input  logic [MAC_NUM*BW_ACT-1:0]   act_rd_data,
  output logic                        PE_mac_enable,
  output logic                        PE_clear_acc,
  output logic signed [BW_WET-1:0]    PE_wet_in,
  output logic signed [BW_ACT-1:0]    PE_act_in [MAC_NUM],
  output logic [7:0]                  PE_res_shift_num,
  input  logic signed [BW_ACT-1:0]    PE_result_out [MAC_NUM],
  output logic                        res_wr_en,
  output logic [T_W-1:0]              res_wr_addr,
  output logic [MAC_NUM*BW_ACT-1:0]   res_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WAIT, S_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_len_q, k_len_d;
  logic [T_W-1:0]    n_tiles_q, n_tiles_d;
  logic [7:0]        shift_q, shift_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [ADDR_W-1:0] wet_addr_q, wet_addr_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      k_len_q    <= '0;
      n_tiles_q  <= '0;
      shift_q    <= '0;
      k_q        <= '0;
      t_q        <= '0;
      wet_addr_q <= '0;
      act_addr_q <= '0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_len_q    <= k_len_d;
      n_tiles_q  <= n_tiles_d;
      shift_q    <= shift_d;
      k_q        <= k_d;
      t_q        <= t_d;
      wet_addr_q <= wet_addr_d;
      act_addr_q <= act_addr_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
    end
  end

  // Address registers hold the address presented this cycle; they advance only
  // when the next cycle issues a read, so they hold while the enable is low.
  always_comb begin
    state_d    = state_q;
    k_len_d    = k_len_q;
    n_tiles_d  = n_tiles_q;
    shift_d    = shift_q;
    k_d        = k_q;
    t_d        = t_q;
    wet_addr_d = wet_addr_q;
    act_addr_d = act_addr_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          k_len_d   = cfg_k_len;
          n_tiles_d = cfg_n_tiles;
          shift_d   = cfg_shift;
          if (cfg_k_len == '0 || cfg_n_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_CLEAR;
            t_d        = '0;
            wet_addr_d = cfg_wet_base;
            act_addr_d = '0;
            rd_en_d    = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        k_d     = '0;
        if (k_len_q > K_W'(1)) begin
          rd_en_d    = 1'b1;
          wet_addr_d = wet_addr_q + ADDR_W'(1);
          act_addr_d = act_addr_q + ADDR_W'(1);
        end
      end
      S_FEED: begin
        if (k_q == k_len_q - K_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + K_W'(1);
          if ((K_W+1)'(k_q) + (K_W+1)'(2) < (K_W+1)'(k_len_q)) begin
            rd_en_d    = 1'b1;
            wet_addr_d = wet_addr_q + ADDR_W'(1);
            act_addr_d = act_addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: state_d = S_WAIT;
      S_WAIT:  state_d = S_WRITE;
      S_WRITE: begin
        if (t_q == n_tiles_q - T_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          // Next tile's weights follow on directly from the last address read.
          state_d    = S_CLEAR;
          t_d        = t_q + T_W'(1);
          wet_addr_d = wet_addr_q + ADDR_W'(1);
          act_addr_d = '0;
          rd_en_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign wet_rd_en        = rd_en_q;
  assign act_rd_en        = rd_en_q;
  assign wet_rd_addr      = wet_addr_q;
  assign act_rd_addr      = act_addr_q;
  assign PE_clear_acc     = (state_q == S_CLEAR);
  assign PE_mac_enable    = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign PE_res_shift_num = shift_q;
  assign res_wr_en        = (state_q == S_WRITE);
  assign res_wr_addr      = t_q;
  assign PE_wet_in        = busy ? $signed(wet_rd_data) : '0;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    assign PE_act_in[i] = busy ? $signed(act_rd_data[i*BW_ACT +: BW_ACT]) : '0;
    assign res_wr_data[i*BW_ACT +: BW_ACT] = res_wr_en ? PE_result_out[i] : '0;
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed job table plus reset/start corner sequences for pe_array_ctrl
module tb_pe_array_ctrl;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        cfg_k_len;
  logic [7:0]        cfg_n_tiles;
  logic [11:0]       cfg_wet_base;
  logic [7:0]        cfg_shift;
  logic              busy, done;
  logic              wet_rd_en, act_rd_en;
  logic [11:0]       wet_rd_addr, act_rd_addr;
  logic [7:0]        wet_rd_data = '0;
  logic [79:0]       act_rd_data = '0;
  logic              PE_mac_enable, PE_clear_acc;
  logic signed [7:0] PE_wet_in;
  logic signed [7:0] PE_act_in [10];
  logic [7:0]        PE_res_shift_num;
  logic signed [7:0] PE_result_out [10];
  logic              res_wr_en;
  logic [7:0]        res_wr_addr;
  logic [79:0]       res_wr_data;

  pe_array_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_k_len(cfg_k_len), .cfg_n_tiles(cfg_n_tiles),
    .cfg_wet_base(cfg_wet_base), .cfg_shift(cfg_shift),
    .busy(busy), .done(done),
    .wet_rd_en(wet_rd_en), .wet_rd_addr(wet_rd_addr), .wet_rd_data(wet_rd_data),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
    .PE_wet_in(PE_wet_in), .PE_act_in(PE_act_in),
    .PE_res_shift_num(PE_res_shift_num), .PE_result_out(PE_result_out),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 clk = ~clk;

  // SRAMs with one-cycle synchronous read
  logic signed [7:0] wmem [4096];
  logic [79:0]       amem [256];
  always @(posedge clk) begin
    if (wet_rd_en) wet_rd_data <= wmem[wet_rd_addr];
    if (act_rd_en) act_rd_data <= amem[act_rd_addr[7:0]];
  end

  // PE array behavioural model: registered inputs, clear beats accumulate,
  // registered shifted/saturated result one cycle after the accumulator.
  logic signed [7:0] act_r [10];
  logic signed [7:0] wet_r = '0;
  logic              clr_r = 1'b0;
  int                acc [10];

  function automatic logic signed [7:0] sat8(input int x);
    if (x > 127) return 8'sd127;
    if (x < -128) return -8'sd128;
    return x[7:0];
  endfunction

  initial begin
    for (int i = 0; i < 10; i++) begin
      acc[i] = 0;
      act_r[i] = '0;
      PE_result_out[i] = '0;
    end
  end

  always @(posedge clk) begin
    wet_r <= PE_wet_in;
    clr_r <= PE_clear_acc;
    for (int i = 0; i < 10; i++) begin
      act_r[i] <= PE_act_in[i];
      if (clr_r) acc[i] <= 0;
      else if (PE_mac_enable) acc[i] <= acc[i] + act_r[i] * wet_r;
      PE_result_out[i] <= sat8(acc[i] >>> PE_res_shift_num);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic any;
    any = busy | done | wet_rd_en | act_rd_en | PE_mac_enable | PE_clear_acc |
          res_wr_en | (|wet_rd_addr) | (|act_rd_addr) | (|PE_res_shift_num) |
          (|res_wr_addr) | (|res_wr_data) | (|PE_wet_in);
    for (int i = 0; i < 10; i++) any = any | (|PE_act_in[i]);
    chk(name, int'(any), 0);
  endtask

  typedef struct {
    int k; int t; int base; int sh;
    bit w_inc; int wv;      // weight = (j%K)+1 when w_inc, else wv
    bit a_lane; int av;     // activation lane i = i when a_lane, else av
    bit e_lane; int ev;     // expected lane i = ev*i when e_lane, else ev
    int exp_busy;
    bit mid_start; bit dc_start;
  } job_t;

  task automatic run_job(input job_t j, input string tag);
    int n, busy_n, wr_n, rd_n, mac_n, clr_n, done_n, exp_wa, exp_aa, expv, nz;
    bit seen;
    for (int x = 0; x < j.t * j.k; x++)
      wmem[(j.base + x) & 'hFFF] = j.w_inc ? 8'((x % j.k) + 1) : 8'(j.wv);
    for (int a = 0; a < j.k; a++)
      for (int i = 0; i < 10; i++)
        amem[a][i*8 +: 8] = j.a_lane ? 8'(i) : 8'(j.av);
    @(negedge clk);
    cfg_k_len = 8'(j.k); cfg_n_tiles = 8'(j.t);
    cfg_wet_base = 12'(j.base); cfg_shift = 8'(j.sh);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_n = 0; wr_n = 0; rd_n = 0; mac_n = 0; clr_n = 0; done_n = -1;
    exp_wa = j.base; seen = 0;
    while (!seen && n < 2000) begin
      if (j.mid_start && n == 5) begin
        cfg_k_len = 8'd1; cfg_n_tiles = 8'd1; cfg_shift = 8'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (PE_mac_enable) mac_n++;
      if (PE_clear_acc) clr_n++;
      if (wet_rd_en || act_rd_en) begin
        exp_aa = (j.k > 0) ? rd_n % j.k : -1;
        chk({tag, " rd_en_pair"}, int'(act_rd_en), int'(wet_rd_en));
        chk({tag, " wet_addr"}, int'(wet_rd_addr), exp_wa & 'hFFF);
        chk({tag, " act_addr"}, int'(act_rd_addr), exp_aa);
        exp_wa++;
        rd_n++;
      end
      if (res_wr_en) begin
        chk({tag, " wr_addr"}, int'(res_wr_addr), wr_n);
        for (int i = 0; i < 10; i++) begin
          expv = j.e_lane ? j.ev * i : j.ev;
          chk($sformatf("%s tile%0d lane%0d", tag, wr_n, i),
              int'($signed(res_wr_data[i*8 +: 8])), expv);
        end
        wr_n++;
      end
      if (done) begin
        seen = 1;
        done_n = n;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    nz = (j.k == 0 || j.t == 0) ? 0 : 1;
    chk({tag, " done_seen"}, int'(seen), 1);
    chk({tag, " done_cycle"}, done_n, j.exp_busy);
    chk({tag, " busy_cycles"}, busy_n, j.exp_busy);
    chk({tag, " writes"}, wr_n, nz * j.t);
    chk({tag, " reads"}, rd_n, nz * j.t * j.k);
    chk({tag, " mac_cycles"}, mac_n, nz * j.t * (j.k + 1));
    chk({tag, " clear_cycles"}, clr_n, nz * j.t);
    chk({tag, " shift_latched"}, int'(PE_res_shift_num), j.sh);
    if (j.dc_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " start_in_done_ignored"}, int'(busy | done), 0);
    end
  endtask

  job_t jobs [8];
  job_t rj;

  initial begin
    //           k  t  base   sh winc wv    lane av    elane ev   busy mid dc
    jobs[0] = '{3, 1, 0,      0, 1,   0,    1,   0,    1,    6,   7,   0,  0};
    jobs[1] = '{4, 3, 'h10,   0, 1,   0,    1,   0,    1,    10,  24,  1,  0};
    jobs[2] = '{8, 1, 'h40,   4, 0,   127,  0,   127,  0,    127, 12,  0,  1};
    jobs[3] = '{2, 1, 'h80,   0, 0,   127,  0,   -128, 0,    -128, 6,  0,  0};
    jobs[4] = '{0, 2, 0,      2, 0,   0,    0,   0,    0,    0,   0,   0,  0};
    jobs[5] = '{3, 0, 0,      3, 0,   0,    0,   0,    0,    0,   0,   0,  0};
    jobs[6] = '{3, 2, 'hFFE,  1, 1,   0,    1,   0,    1,    3,   14,  0,  0};
    jobs[7] = '{2, 1, 'h100,  1, 0,   -3,   1,   0,    1,    -3,  6,   0,  0};
    for (int a = 0; a < 4096; a++) wmem[a] = '0;
    for (int a = 0; a < 256; a++) amem[a] = '0;

    reset_n = 1'b0; start = 1'b0;
    cfg_k_len = '0; cfg_n_tiles = '0; cfg_wet_base = '0; cfg_shift = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_reset");

    for (int r = 0; r < 8; r++) run_job(jobs[r], $sformatf("job%0d", r));

    // Reset during FEED of tile 1 of a two-tile job
    for (int x = 0; x < 8; x++) wmem['h200 + x] = 8'((x % 4) + 1);
    for (int a = 0; a < 4; a++)
      for (int i = 0; i < 10; i++) amem[a][i*8 +: 8] = 8'(i);
    @(negedge clk);
    cfg_k_len = 8'd4; cfg_n_tiles = 8'd2; cfg_wet_base = 12'h200; cfg_shift = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_feed", int'(PE_mac_enable & busy), 1);
    reset_n = 1'b0;
    #1;
    chk_zero("reset_mid_job");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_in_reset", int'(done | busy), 0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("no_done_after_reset", int'(done | busy), 0);
    end
    rj = '{2, 1, 'h300, 0, 1, 0, 1, 0, 1, 3, 6, 0, 0};
    run_job(rj, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Initiator/sequencer for the PE array MAC interface. It drives the PE array with weights, activations, mac-enable, clear-acc and shift.
- It computes one output channel per "tile": a K-length dot product across MAC_NUM lanes. It then collects the saturated int8 results and writes them to a result buffer.
- Sits between the weight/activation SRAMs (1-cycle synchronous read) and the PE array.

Parameters:
- MAC_NUM, 10, PE lanes
- BW_ACT, 8, activation/result width
- BW_WET, 8, weight width
- ADDR_W, 12, SRAM address width
- K_W, 8, width of k_len
- T_W, 8, width of n_tiles

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  single-cycle launch pulse; ignored while busy
- cfg_k_len  in  K_W  dot-product length K
- cfg_n_tiles  in  T_W  number of output channels T
- cfg_wet_base  in  ADDR_W  weight SRAM base address
- cfg_shift  in  8  result right-shift amount
- busy  out  1  high while a job runs
- done  out  1  one-cycle pulse at job end
- wet_rd_en  out  1  weight SRAM read enable
- wet_rd_addr  out  ADDR_W  weight SRAM address
- wet_rd_data  in  BW_WET  weight read data, valid the cycle after wet_rd_en
- act_rd_en  out  1  activation SRAM read enable
- act_rd_addr  out  ADDR_W  activation SRAM address
- act_rd_data  in  MAC_NUM*BW_ACT  packed activation word; lane i occupies bits [(i+1)*BW_ACT-1 : i*BW_ACT]
- PE_mac_enable  out  1  to PE array
- PE_clear_acc  out  1  to PE array
- PE_wet_in  out  BW_WET signed  = wet_rd_data (combinational forward)
- PE_act_in  out  [MAC_NUM] x BW_ACT signed  = lanes of act_rd_data (combinational forward)
- PE_res_shift_num  out  8  latched cfg_shift
- PE_result_out  in  [MAC_NUM] x BW_ACT signed  PE results
- res_wr_en  out  1  result buffer write enable
- res_wr_addr  out  T_W  result buffer address (= tile index)
- res_wr_data  out  MAC_NUM*BW_ACT  packed PE_result_out; lane i in the same bit position as act_rd_data

Behaviour:
- Reset (async):
  - State is IDLE.
  - All outputs are 0, including busy, done, enables, addresses and PE_res_shift_num.
  - Reset mid-job aborts immediately; there is no done pulse.
- PE contract this block is built around:
  - The PE array registers act/wet/clear one cycle, then accumulates on PE_mac_enable; clear wins over accumulate.
  - It produces a registered, shifted, saturated result one cycle after the accumulator.
- Job launch:
  - start in IDLE latches all cfg_* values.
  - If K=0 or T=0: done pulses in the next cycle, busy stays 0, and there is no SRAM or PE activity.
  - Otherwise busy rises the next cycle and stays high through the final WRITE cycle.
- States:
  - IDLE: waits for start.
  - CLEAR: exactly 1 cycle per tile (tile start = cycle C).
  - FEED: cycles C+1..C+K.
  - DRAIN: cycle C+K+1.
  - WAIT: cycle C+K+2.
  - WRITE: cycle C+K+3.
  - After WRITE: next tile's CLEAR, or after tile T-1 go to IDLE with done=1 for one cycle.
- Per tile t, with k = 0..K-1:
  - CLEAR (cycle C): PE_clear_acc=1, PE_mac_enable=0; issue reads for k=0.
  - FEED cycle C+1+k: PE_mac_enable=1; SRAM data for element k is forwarded to the PE; reads for k+1 are issued when k+1<K.
  - DRAIN: PE_mac_enable=1 (accumulates element K-1); no reads.
  - WAIT: PE_mac_enable=0; the PE result register updates.
  - WRITE: res_wr_en=1, res_wr_addr=t, res_wr_data=packed PE_result_out.
- Addresses:
  - wet_rd_addr = cfg_wet_base + t*K + k.
  - act_rd_addr = k; activations are reused for every tile.
  - Both are generated with running counters, not multipliers.
  - wet_rd_en and act_rd_en are always asserted together.
- Timing totals: one tile takes K+4 cycles; a job takes T*(K+4) cycles of busy; done follows the final WRITE by 1 cycle.
- Outside their active cycles, PE_clear_acc, PE_mac_enable, the read enables and res_wr_en are 0.
- Address outputs hold their last value when their enable is low.
- PE_res_shift_num holds the latched shift from the start of a job until the next accepted start.
- Counter wrap: wet address addition wraps modulo 2^ADDR_W; no error is flagged.
- start during busy (including in the done cycle) is ignored. A new start is accepted in the first IDLE cycle after done.

Test Plan:
1. Reset, then K=3, T=1, shift=0, weights {1,2,3}, lane i activations {i,i,i} -> lane i result 6i (lane 9 = 54); single write to addr 0 at cycle C+6; busy high 7 cycles; done one cycle after.
2. K=4, T=3, wet_base=0x10 -> weight reads at 0x10..0x1B in order; activation addresses 0..3 repeated per tile; writes to addrs 0,1,2; busy duration 24 cycles.
3. Saturation/shift: weights 127, activations 127, K=8, shift=4 -> 129032>>>4 = 8064 -> all lanes 127. Activations -128, weight 127, shift=0 -> all lanes -128.
4. Edge cases: K=0 -> done next cycle, no reads/writes. A start pulse mid-job -> ignored, cycle count unchanged. Back-to-back start in the first IDLE cycle -> accepted.
5. Assert reset_n low during FEED of tile 1 -> all outputs 0 immediately, no done. A subsequent job with K=2, T=1 gives correct results (accumulator cleared by CLEAR).
